// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequenced ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7
  } opcode_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_E = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Multi-cycle datapath: one-bit-per-cycle shifter and LSB-first shift-add multiplier.
// o_done and the o_* results describe the step taken on the coming clock edge.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH),
  localparam int CW    = SHW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_carry
);

  logic                 r_mul;
  logic                 r_shr;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_sh;

  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     w_sh_nxt;

  always_comb begin
    w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_sh_nxt  = r_shr ? {1'b0, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};
  end

  assign o_done  = (r_count == CW'(1));
  assign o_lo    = r_mul ? w_acc_nxt[WIDTH-1:0] : w_sh_nxt;
  assign o_hi    = r_mul ? w_acc_nxt[2*WIDTH-1:WIDTH] : '0;
  assign o_carry = r_shr ? r_sh[0] : r_sh[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mul    <= 1'b0;
      r_shr    <= 1'b0;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sh     <= '0;
    end else if (i_load) begin
      r_mul    <= (i_op == OP_MUL);
      r_shr    <= (i_op == OP_SHR);
      r_count  <= (i_op == OP_MUL) ? CW'(WIDTH) : {1'b0, i_b[SHW-1:0]};
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_sh     <= i_a;
    end else if (r_count != '0) begin
      // Both datapaths step together; only the one selected by r_mul is reported.
      r_count  <= r_count - CW'(1);
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_sh     <= w_sh_nxt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops and all flag generation here, shifts/multiply
// delegated to alu_iter_unit. Result registers hold until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flag
);

  state_e           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_out_hi;
  logic [3:0]       r_flag;

  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_iter_start;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_sc_res;
  logic [3:0]       w_sc_flag;
  logic             w_it_done;
  logic [WIDTH-1:0] w_it_lo;
  logic [WIDTH-1:0] w_it_hi;
  logic             w_it_cout;
  logic [3:0]       w_it_flag;

  // in_ready is a registered copy of "next state is IDLE", so it stays low while in reset.
  assign w_accept     = (r_state == S_IDLE) && r_in_ready && in_valid;
  assign w_iter_start = w_accept &&
                        ((opcode == OP_MUL) || (is_shift(opcode) && (b[SHW-1:0] != '0)));

  always_comb begin
    w_sum     = {1'b0, a} + {1'b0, b};
    w_diff    = {1'b0, a} - {1'b0, b};
    w_sc_res  = '0;
    w_sc_flag = '0;
    case (opcode)
      OP_ADD: begin
        w_sc_res          = w_sum[WIDTH-1:0];
        w_sc_flag[FLAG_C] = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sc_res          = w_diff[WIDTH-1:0];
        w_sc_flag[FLAG_C] = w_diff[WIDTH];
      end
      OP_AND:         w_sc_res = a & b;
      OP_OR:          w_sc_res = a | b;
      OP_XOR:         w_sc_res = a ^ b;
      OP_SHL, OP_SHR: w_sc_res = a;
      OP_MUL:         w_sc_res = '0;
      default:        w_sc_flag[FLAG_E] = 1'b1;
    endcase
    w_sc_flag[FLAG_N] = w_sc_res[WIDTH-1];
    w_sc_flag[FLAG_Z] = (w_sc_res == '0);
  end

  always_comb begin
    w_it_flag         = '0;
    w_it_flag[FLAG_C] = (r_op == OP_MUL) ? (w_it_hi != '0) : w_it_cout;
    w_it_flag[FLAG_N] = w_it_lo[WIDTH-1];
    w_it_flag[FLAG_Z] = ({w_it_hi, w_it_lo} == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_iter_start ? S_EXEC : S_DONE;
      S_EXEC:  if (w_it_done) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_op        <= '0;
      r_out       <= '0;
      r_out_hi    <= '0;
      r_flag      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op <= opcode;
        if (!w_iter_start) begin
          r_out    <= w_sc_res;
          r_out_hi <= '0;
          r_flag   <= w_sc_flag;
        end
      end else if ((r_state == S_EXEC) && w_it_done) begin
        r_out    <= w_it_lo;
        r_out_hi <= w_it_hi;
        r_flag   <= w_it_flag;
      end
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_iter_start),
    .i_op    (opcode),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_it_done),
    .o_lo    (w_it_lo),
    .o_hi    (w_it_hi),
    .o_carry (w_it_cout)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_hi    = r_out_hi;
  assign flag      = r_flag;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed table, corner sequences, random vs model.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [7:0] out_hi;
  logic [3:0] flag;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] flag;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] flag;
    int         lat;
  } res_t;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .flag      (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic res_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    res_t r;
    int   ix, iy, amt, p;
    logic c, e, z;
    ix = int'(x);
    iy = int'(y);
    amt = iy % 8;
    p = 0;
    c = 1'b0;
    e = 1'b0;
    r.hi = 8'h00;
    r.lat = 1;
    case (op)
      4'd0: begin p = ix + iy; c = (p > 255); end
      4'd1: begin p = ix - iy; c = (ix < iy); end
      4'd2: p = ix & iy;
      4'd3: p = ix | iy;
      4'd4: p = ix ^ iy;
      4'd5: begin
        p = ix << amt;
        c = (amt != 0) && (((ix >> (8 - amt)) & 1) == 1);
        r.lat = 1 + amt;
      end
      4'd6: begin
        p = ix >> amt;
        c = (amt != 0) && (((ix >> (amt - 1)) & 1) == 1);
        r.lat = 1 + amt;
      end
      4'd7: begin
        p = ix * iy;
        r.hi = 8'(p >> 8);
        c = ((p >> 8) != 0);
        r.lat = 9;
      end
      default: e = 1'b1;
    endcase
    r.lo = 8'(p & 255);
    z = (op == 4'd7) ? (p == 0) : (r.lo == 8'h00);
    r.flag = {c, r.lo[7], z, e};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offer one op, wait for out_valid; lat counts edges from the accept edge inclusive.
  task automatic do_op(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                       output logic [7:0] ro, output logic [7:0] rh, output logic [3:0] rf,
                       output int lat, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    lat = 0;
    ro = 8'h00; rh = 8'h00; rf = 4'h0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin to = 1'b1; return; end
    in_valid = 1'b1; opcode = op; a = ia; b = ib;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; lat++; n++; end
    if (!out_valid) to = 1'b1;
    ro = out; rh = out_hi; rf = flag;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic apply(input string tag, input logic [3:0] op, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [7:0] elo, input logic [7:0] ehi,
                       input logic [3:0] ef, input int elat);
    logic [7:0] ro, rh;
    logic [3:0] rf;
    int lat;
    bit to;
    do_op(op, ia, ib, ro, rh, rf, lat, to);
    chk({tag, " timeout"}, 32'(to), 32'd0);
    if (!to) begin
      chk({tag, " out"}, 32'(ro), 32'(elo));
      chk({tag, " out_hi"}, 32'(rh), 32'(ehi));
      chk({tag, " flag"}, 32'(rf), 32'(ef));
      chk({tag, " latency"}, 32'(lat), 32'(elat));
    end
    release_out();
  endtask

  vec_t vecs[$];
  res_t m;

  initial begin
    logic [7:0] ro, rh;
    logic [3:0] rf, op;
    logic [7:0] ra, rb;
    int lat;
    bit to;
    bit seen;

    vecs.push_back('{4'h0, 8'hF0, 8'h20, 8'h10, 8'h00, 4'b1000, 1});
    vecs.push_back('{4'h0, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1010, 1});
    vecs.push_back('{4'h1, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b1100, 1});
    vecs.push_back('{4'h1, 8'h33, 8'h33, 8'h00, 8'h00, 4'b0010, 1});
    vecs.push_back('{4'h5, 8'h81, 8'h03, 8'h08, 8'h00, 4'b0000, 4});
    vecs.push_back('{4'h6, 8'h01, 8'h00, 8'h01, 8'h00, 4'b0000, 1});
    vecs.push_back('{4'h7, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 9});
    vecs.push_back('{4'hA, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0011, 1});
    vecs.push_back('{4'h6, 8'h03, 8'h01, 8'h01, 8'h00, 4'b1000, 2});
    vecs.push_back('{4'h6, 8'h80, 8'h07, 8'h01, 8'h00, 4'b0000, 8});
    vecs.push_back('{4'h5, 8'h80, 8'h01, 8'h00, 8'h00, 4'b1010, 2});
    vecs.push_back('{4'h5, 8'h81, 8'h0B, 8'h08, 8'h00, 4'b0000, 4});
    vecs.push_back('{4'h7, 8'h00, 8'h05, 8'h00, 8'h00, 4'b0010, 9});
    vecs.push_back('{4'h7, 8'h10, 8'h08, 8'h80, 8'h00, 4'b0100, 9});
    vecs.push_back('{4'h2, 8'hF0, 8'h0F, 8'h00, 8'h00, 4'b0010, 1});
    vecs.push_back('{4'h4, 8'hFF, 8'h0F, 8'hF0, 8'h00, 4'b0100, 1});
    vecs.push_back('{4'h3, 8'h41, 8'h02, 8'h43, 8'h00, 4'b0000, 1});
    vecs.push_back('{4'hF, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0011, 1});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 4'h0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset outputs", {8'h00, out_hi, out, 4'h0, flag}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].lo, vecs[i].hi, vecs[i].flag, vecs[i].lat);

    // Result held with consumer stalled.
    do_op(4'h7, 8'hFF, 8'hFF, ro, rh, rf, lat, to);
    chk("hold timeout", 32'(to), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold cyc%0d", k), {10'd0, out_valid, in_ready, out_hi, out, flag},
          {10'd0, 1'b1, 1'b0, 8'hFE, 8'h01, 4'b1000});
    end
    release_out();

    // Back-to-back: second op waits for the DONE->IDLE cycle.
    do_op(4'h0, 8'h01, 8'h02, ro, rh, rf, lat, to);
    chk("b2b first out", {23'd0, to, ro}, 32'h03);
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = 4'h4; a = 8'h0F; b = 8'hFF;
    @(posedge clk); #1;
    chk("b2b idle cycle", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b second", {18'd0, out_valid, in_ready, out, flag}, {18'd0, 1'b1, 1'b0, 8'hF0, 4'b0100});
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b back to idle", {30'd0, out_valid, in_ready}, 32'b01);

    // Reset during MUL EXEC abandons the operation.
    in_valid = 1'b1; opcode = 4'h7; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst outputs", {11'd0, out_valid, out_hi, out, flag}, 32'd0);
    @(posedge clk); #1;
    chk("midrst in_ready", {30'd0, out_valid, in_ready}, 32'b01);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    chk("midrst no stale result", 32'(seen), 32'd0);
    apply("post-reset add", 4'h0, 8'h10, 8'h22, 8'h32, 8'h00, 4'b0000, 1);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      m = model(op, ra, rb);
      apply($sformatf("rand%0d op%0h a%0h b%0h", i, op, ra, rb), op, ra, rb,
            m.lo, m.hi, m.flag, m.lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. Accepts one operation at a time over a valid/ready input channel and computes add, sub, logic, multi-bit shifts and an iterative multiply. Returns a registered result plus flags over a valid/ready output channel. Sits between the instruction decode/operand fetch stage and the register write-back stage of the microprocessor datapath.

## Interface
- WIDTH, 8: operand/result width, ≥ 4, power of two.
- SHW, $clog2(WIDTH): derived, not overridable; width of the shift amount.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept; high only in IDLE.
- opcode  input  4  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; shift ops use b[SHW-1:0] as the amount.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result, low half for MUL.
- out_hi  output  WIDTH  MUL high half; 0 for all other ops.
- flag  output  4  {C, N, Z, E} = bits [3:0].

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHL, 0110 SHR (logical), 0111 MUL (unsigned). 1000–1111 are illegal.
- Flags are set independently; multiple bits may be 1 at once.
- Z = (out == 0). For MUL, Z = ({out_hi, out} == 0).
- N = out[WIDTH-1].
- C for ADD: carry-out of a+b.
- C for SUB: borrow, i.e. a < b unsigned.
- C for SHL/SHR: last bit shifted out; 0 if the amount is 0.
- C for MUL: out_hi != 0.
- C for logic ops: 0.
- E = 1 only for illegal opcodes. For illegal opcodes: out = 0, out_hi = 0, flag = 4'b0011 (Z and E set).
- FSM states:
  - IDLE: in_ready = 1. An in_valid&in_ready handshake latches opcode/a/b. Single-cycle ops go to DONE. SHL/SHR with amount > 0 go to EXEC with count = amount. MUL goes to EXEC with count = WIDTH.
  - EXEC: shifts move one bit per cycle. MUL does one shift-add step per cycle (multiplier LSB first, 2·WIDTH accumulator). count decrements each cycle; at count == 1 the final result and flags are written and the FSM goes to DONE.
  - DONE: out_valid = 1. out/out_hi/flag are held stable until out_valid & out_ready, then the FSM returns to IDLE.
- Inputs are ignored outside the IDLE handshake. Operands changing during EXEC have no effect.

## Timing
- Reset values: in_ready = 0 during reset and 1 in the first cycle after; out_valid = 0, out = 0, out_hi = 0, flag = 0, state = IDLE, count = 0.
- Reset mid-operation (EXEC or DONE) abandons the operation. Its result is never presented.
- Latency, counted from the accept edge to out_valid high:
  - ADD/SUB/logic/illegal, and shifts with amount 0: 1 cycle.
  - SHL/SHR: 1 + amount cycles.
  - MUL: 1 + WIDTH cycles.
- No pipelining; throughput is one operation per (latency + 1) cycles at best. DONE → IDLE costs one cycle even if out_ready was already high.
- No combinational path from in_valid or out_ready to any output. in_ready is a state decode only.
- Width rules: ADD/SUB use a WIDTH+1-bit internal sum for C. MUL accumulates into 2·WIDTH bits; no truncation before split.

## Structure
- Package alu_pkg holds:
  - opcode enum (OP_ADD … OP_MUL),
  - flag bit indices (FLAG_C = 3, FLAG_N = 2, FLAG_Z = 1, FLAG_E = 0),
  - FSM state enum (S_IDLE, S_EXEC, S_DONE).
- Sub-module alu_iter_unit holds the shift/multiply datapath: load, step, and accumulator/count registers. It exposes a done pulse to the top FSM.
- Single-cycle ops and flag generation stay in alu_seq.

## Test plan
- WIDTH=8, ADD a=0xF0 b=0x20 → one cycle later out_valid, out=0x10, flag=4'b1000. Repeat with a=0x80 b=0x80 → out=0x00, flag=4'b1010.
- SUB a=0x05 b=0x07 → out=0xFE, flag=4'b1100. SUB a=0x33 b=0x33 → out=0x00, flag=4'b0010.
- SHL a=0x81 b=3 → out_valid exactly 4 cycles after accept, out=0x08, flag=4'b0000 (last bit out = 0). SHR a=0x01 b=0 → 1 cycle, out=0x01, flag=0.
- MUL a=0xFF b=0xFF → out_valid 9 cycles after accept, out=0x01, out_hi=0xFE, flag=4'b1000. Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0 throughout.
- Opcode 4'b1010 → out=0, flag=4'b0011 after 1 cycle. Back-to-back in_valid with out_ready=1 → second op is accepted only after the DONE→IDLE cycle.
- Assert rst_n=0 for one cycle during MUL EXEC → next cycle out_valid=0, flag=0, in_ready=1. A new ADD then completes normally.
